// File: rtl/alarm_ui_pkg.sv
// Shared types and constants for the alarm-clock button sequencer.
// Pure declarations: no logic and no latency of its own.
// No flow control; the types describe single-cycle pulses and display state.
package alarm_ui_pkg;

    typedef enum logic [3:0] {
        ST_INIT,
        ST_IDLE,
        ST_EDIT_TIME,
        ST_EDIT_ALARM,
        ST_COMMIT,
        ST_SNZ_STOP,
        ST_SNZ_LD,
        ST_DIS_STOP,
        ST_DIS_LD
    } state_e;

    typedef enum logic [1:0] {
        FLD_HOUR = 2'd0,
        FLD_MIN  = 2'd1,
        FLD_SEC  = 2'd2
    } field_e;

    typedef struct packed {
        logic [5:0] hour;
        logic [5:0] min;
        logic [5:0] sec;
    } hms_t;

    localparam logic [5:0] MAX_HOUR   = 6'd23;
    localparam logic [5:0] MAX_MINSEC = 6'd59;

    localparam logic [1:0] MODE_RUN   = 2'd0;
    localparam logic [1:0] MODE_TIME  = 2'd1;
    localparam logic [1:0] MODE_ALARM = 2'd2;

    // Increment with wrap to zero; out-of-range inputs also land on zero.
    function automatic logic [5:0] wrap_inc(input logic [5:0] v, input logic [5:0] max_v);
        return (v >= max_v) ? 6'd0 : v + 6'd1;
    endfunction

endpackage

// File: rtl/btn_edge.sv
// Registers one debounced button level and flags its rising edge.
// Event is combinational from the raw level and the one-cycle-old copy.
// No backpressure: a held button yields exactly one event.
module btn_edge (
    input  logic clk,
    input  logic reset,
    input  logic btn,
    output logic evt
);

    logic btn_d;
    logic btn_q;

    // Next value of the level register is simply the current input.
    always_comb begin
        btn_d = btn;
    end

    // Remember last cycle's level so a press is seen once.
    always_ff @(posedge clk) begin
        if (reset) begin
            btn_q <= 1'b0;
        end else begin
            btn_q <= btn_d;
        end
    end

    assign evt = btn & ~btn_q;

endmodule

// File: rtl/alarm_set_ctrl.sv
// Turns button events into LD_time/LD_alarm/stop_alarm pulses for the clock core.
// Pulses are registered: they appear the cycle after the detecting edge, one cycle wide.
// No backpressure: events arriving while a pulse sequence is in flight are dropped.
module alarm_set_ctrl #(
    parameter int SNOOZE_MIN      = 5,
    parameter int TIMEOUT_TICKS   = 300,
    parameter int INIT_ALARM_HOUR = 6
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       btn_mode,
    input  logic       btn_next,
    input  logic       btn_inc,
    input  logic       btn_snooze,
    input  logic       alarm,
    input  logic [5:0] cur_sec,
    input  logic [5:0] cur_min,
    input  logic [5:0] cur_hour,
    output logic       LD_time,
    output logic       LD_alarm,
    output logic       stop_alarm,
    output logic [5:0] sec_in,
    output logic [5:0] min_in,
    output logic [5:0] hour_in,
    output logic [1:0] mode,
    output logic [1:0] edit_field
);

    import alarm_ui_pkg::*;

    localparam int             CNT_W   = $clog2(TIMEOUT_TICKS + 1);
    localparam logic [CNT_W-1:0] TO_LAST = CNT_W'(TIMEOUT_TICKS - 1);
    localparam hms_t           INIT_ALARM = '{hour: 6'(INIT_ALARM_HOUR), min: 6'd0, sec: 6'd0};

    logic ev_mode, ev_next, ev_inc, ev_snooze, any_ev;

    btn_edge u_edge_mode   (.clk(clk), .reset(reset), .btn(btn_mode),   .evt(ev_mode));
    btn_edge u_edge_next   (.clk(clk), .reset(reset), .btn(btn_next),   .evt(ev_next));
    btn_edge u_edge_inc    (.clk(clk), .reset(reset), .btn(btn_inc),    .evt(ev_inc));
    btn_edge u_edge_snooze (.clk(clk), .reset(reset), .btn(btn_snooze), .evt(ev_snooze));

    assign any_ev = ev_mode | ev_next | ev_inc | ev_snooze;

    hms_t cur_hms;
    assign cur_hms = '{hour: cur_hour, min: cur_min, sec: cur_sec};

    state_e           state_q, state_d;
    field_e           field_q, field_d;
    hms_t             edit_q, edit_d;
    hms_t             shadow_q, shadow_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             ld_time_q, ld_time_d;
    logic             ld_alarm_q, ld_alarm_d;
    logic             stop_q, stop_d;
    hms_t             load_q, load_d;
    logic [1:0]       mode_q, mode_d;

    hms_t       snz_hms;
    logic [6:0] snz_m;

    // Snooze target: captured time (held in the edit registers) plus SNOOZE_MIN, hour carry only.
    always_comb begin
        snz_hms = edit_q;
        snz_m   = {1'b0, edit_q.min} + 7'(SNOOZE_MIN);
        if (snz_m >= 7'd60) begin
            snz_m        = snz_m - 7'd60;
            snz_hms.hour = wrap_inc(edit_q.hour, MAX_HOUR);
        end
        snz_hms.min = snz_m[5:0];
    end

    // Sequencer next state; pulse outputs are decided on the edge that enters the pulse state.
    always_comb begin
        state_d    = state_q;
        field_d    = field_q;
        edit_d     = edit_q;
        shadow_d   = shadow_q;
        cnt_d      = cnt_q;
        ld_time_d  = 1'b0;
        ld_alarm_d = 1'b0;
        stop_d     = 1'b0;
        load_d     = '0;
        mode_d     = MODE_RUN;

        unique case (state_q)
            // The core's alarm registers have no reset, so push the shadow once.
            ST_INIT: begin
                ld_alarm_d = 1'b1;
                load_d     = shadow_q;
                state_d    = ST_IDLE;
            end
            ST_IDLE: begin
                if (alarm) begin
                    if (ev_mode) begin
                        stop_d  = 1'b1;
                        state_d = ST_DIS_STOP;
                    end else if (ev_snooze) begin
                        stop_d  = 1'b1;
                        edit_d  = cur_hms;
                        state_d = ST_SNZ_STOP;
                    end
                end else if (ev_mode) begin
                    edit_d  = cur_hms;
                    field_d = FLD_HOUR;
                    cnt_d   = '0;
                    state_d = ST_EDIT_TIME;
                end
            end
            ST_EDIT_TIME, ST_EDIT_ALARM: begin
                cnt_d = any_ev ? '0 : cnt_q + CNT_W'(1);
                if (ev_mode) begin
                    if (state_q == ST_EDIT_TIME) begin
                        edit_d  = shadow_q;
                        field_d = FLD_HOUR;
                        state_d = ST_EDIT_ALARM;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end else if (ev_next) begin
                    unique case (field_q)
                        FLD_HOUR: field_d = FLD_MIN;
                        FLD_MIN:  field_d = FLD_SEC;
                        default: begin
                            load_d  = edit_q;
                            state_d = ST_COMMIT;
                            if (state_q == ST_EDIT_TIME) begin
                                ld_time_d = 1'b1;
                            end else begin
                                ld_alarm_d = 1'b1;
                                shadow_d   = edit_q;
                            end
                        end
                    endcase
                end else if (ev_inc) begin
                    unique case (field_q)
                        FLD_HOUR: edit_d.hour = wrap_inc(edit_q.hour, MAX_HOUR);
                        FLD_MIN:  edit_d.min  = wrap_inc(edit_q.min, MAX_MINSEC);
                        default:  edit_d.sec  = wrap_inc(edit_q.sec, MAX_MINSEC);
                    endcase
                end else if (cnt_q == TO_LAST) begin
                    state_d = ST_IDLE;
                end
            end
            ST_SNZ_STOP: begin
                ld_alarm_d = 1'b1;
                load_d     = snz_hms;
                state_d    = ST_SNZ_LD;
            end
            ST_DIS_STOP: begin
                ld_alarm_d = 1'b1;
                load_d     = shadow_q;
                state_d    = ST_DIS_LD;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // Display follows the state being entered; the field selector parks on hour outside edits.
        unique case (state_d)
            ST_EDIT_TIME:  mode_d = MODE_TIME;
            ST_EDIT_ALARM: mode_d = MODE_ALARM;
            default: begin
                mode_d  = MODE_RUN;
                field_d = FLD_HOUR;
            end
        endcase
    end

    // Single state/output register bank; reset drops any pending pulse and restarts at INIT.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= ST_INIT;
            field_q    <= FLD_HOUR;
            edit_q     <= '0;
            shadow_q   <= INIT_ALARM;
            cnt_q      <= '0;
            ld_time_q  <= 1'b0;
            ld_alarm_q <= 1'b0;
            stop_q     <= 1'b0;
            load_q     <= '0;
            mode_q     <= MODE_RUN;
        end else begin
            state_q    <= state_d;
            field_q    <= field_d;
            edit_q     <= edit_d;
            shadow_q   <= shadow_d;
            cnt_q      <= cnt_d;
            ld_time_q  <= ld_time_d;
            ld_alarm_q <= ld_alarm_d;
            stop_q     <= stop_d;
            load_q     <= load_d;
            mode_q     <= mode_d;
        end
    end

    assign LD_time    = ld_time_q;
    assign LD_alarm   = ld_alarm_q;
    assign stop_alarm = stop_q;
    assign hour_in    = load_q.hour;
    assign min_in     = load_q.min;
    assign sec_in     = load_q.sec;
    assign mode       = mode_q;
    assign edit_field = field_q;

endmodule

// File: tb/tb_alarm_set_ctrl.sv
// Scoreboard bench for alarm_set_ctrl against a time-arithmetic reference model.
// Stimulus pushes expected pulses (kind, value, cycle); a negedge monitor pops and compares.
// Directed scenarios first, then randomized button presses.
module tb_alarm_set_ctrl;

    localparam int SNZ    = 5;
    localparam int TO     = 300;
    localparam int INIT_H = 6;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       btn_mode = 1'b0, btn_next = 1'b0, btn_inc = 1'b0, btn_snooze = 1'b0;
    logic       alarm = 1'b0;
    logic [5:0] cur_sec = '0, cur_min = '0, cur_hour = '0;
    logic       LD_time, LD_alarm, stop_alarm;
    logic [5:0] sec_in, min_in, hour_in;
    logic [1:0] mode, edit_field;

    alarm_set_ctrl #(.SNOOZE_MIN(SNZ), .TIMEOUT_TICKS(TO), .INIT_ALARM_HOUR(INIT_H)) dut (
        .clk(clk), .reset(reset),
        .btn_mode(btn_mode), .btn_next(btn_next), .btn_inc(btn_inc), .btn_snooze(btn_snooze),
        .alarm(alarm), .cur_sec(cur_sec), .cur_min(cur_min), .cur_hour(cur_hour),
        .LD_time(LD_time), .LD_alarm(LD_alarm), .stop_alarm(stop_alarm),
        .sec_in(sec_in), .min_in(min_in), .hour_in(hour_in),
        .mode(mode), .edit_field(edit_field)
    );

    always #50 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // kind: 0 = LD_time, 1 = LD_alarm, 2 = stop_alarm
    typedef struct {
        int kind;
        int h;
        int m;
        int s;
        int at;
    } exp_t;

    exp_t sbq[$];
    int   total = 0;
    int   bad   = 0;

    // Reference model: 0 run, 1 edit time, 2 edit alarm
    int st = 0;
    int f  = 0;
    int e[3];
    int sh[3];

    function automatic void push(input int k, input int h, input int m, input int s, input int at);
        exp_t x;
        x.kind = k; x.h = h; x.m = m; x.s = s; x.at = at;
        sbq.push_back(x);
    endfunction

    task automatic chk(input string name, input int got, input int want);
        total++;
        if (got != want) begin
            bad++;
            $display("FAIL %s got=%0d want=%0d (cyc %0d)", name, got, want, cyc);
        end
    endtask

    function automatic void model_reset();
        st = 0; f = 0;
        sh[0] = INIT_H; sh[1] = 0; sh[2] = 0;
        e[0] = 0; e[1] = 0; e[2] = 0;
    endfunction

    function automatic void model_event(input bit m, input bit n, input bit i, input bit s);
        int at;
        int t;
        at = cyc + 1;
        if (st == 0) begin
            if (alarm) begin
                if (m) begin
                    push(2, 0, 0, 0, at);
                    push(1, sh[0], sh[1], sh[2], at + 1);
                end else if (s) begin
                    t = (int'(cur_hour) * 60 + int'(cur_min) + SNZ) % 1440;
                    push(2, 0, 0, 0, at);
                    push(1, t / 60, t % 60, int'(cur_sec), at + 1);
                end
            end else if (m) begin
                st = 1; f = 0;
                e[0] = int'(cur_hour); e[1] = int'(cur_min); e[2] = int'(cur_sec);
            end
        end else if (m) begin
            if (st == 1) begin
                st = 2; f = 0; e = sh;
            end else begin
                st = 0; f = 0;
            end
        end else if (n) begin
            if (f == 2) begin
                push((st == 1) ? 0 : 1, e[0], e[1], e[2], at);
                if (st == 2) sh = e;
                st = 0; f = 0;
            end else begin
                f++;
            end
        end else if (i) begin
            e[f] = (e[f] + 1) % ((f == 0) ? 24 : 60);
        end
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One press: high for one cycle, then two quiet cycles so any pulse sequence drains.
    task automatic press(input bit m, input bit n, input bit i, input bit s);
        btn_mode = m; btn_next = n; btn_inc = i; btn_snooze = s;
        model_event(m, n, i, s);
        tick();
        btn_mode = 0; btn_next = 0; btn_inc = 0; btn_snooze = 0;
        tick();
        tick();
        chk("mode", int'(mode), st);
        chk("edit_field", int'(edit_field), f);
    endtask

    task automatic release_reset();
        model_reset();
        reset = 1'b0;
        push(1, INIT_H, 0, 0, cyc + 1);
        tick();
        tick();
    endtask

    // Monitor: every pulse must match the head of the scoreboard in kind, value and cycle.
    exp_t mx;
    int   mk;
    always @(negedge clk) begin
        if (LD_time || LD_alarm || stop_alarm) begin
            total++;
            if ((int'(LD_time) + int'(LD_alarm) + int'(stop_alarm)) > 1) begin
                bad++;
                $display("FAIL pulse_overlap time=%0b alarm=%0b stop=%0b want one-hot (cyc %0d)",
                         LD_time, LD_alarm, stop_alarm, cyc);
            end
            mk = LD_time ? 0 : (LD_alarm ? 1 : 2);
            total++;
            if (sbq.size() == 0) begin
                bad++;
                $display("FAIL unexpected_pulse kind=%0d %0d:%0d:%0d want none (cyc %0d)",
                         mk, hour_in, min_in, sec_in, cyc);
            end else begin
                mx = sbq.pop_front();
                if (mx.kind != mk || mx.at != cyc || mx.h != int'(hour_in) ||
                    mx.m != int'(min_in) || mx.s != int'(sec_in)) begin
                    bad++;
                    $display("FAIL pulse got kind=%0d %0d:%0d:%0d cyc=%0d want kind=%0d %0d:%0d:%0d cyc=%0d",
                             mk, hour_in, min_in, sec_in, cyc, mx.kind, mx.h, mx.m, mx.s, mx.at);
                end
            end
        end else begin
            total++;
            if (hour_in != 0 || min_in != 0 || sec_in != 0) begin
                bad++;
                $display("FAIL idle_values got=%0d:%0d:%0d want=0:0:0 (cyc %0d)",
                         hour_in, min_in, sec_in, cyc);
            end
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog expired at cyc %0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        int start;
        int entry;
        int exit_c;
        int r;

        model_reset();
        // Reset state
        tick(); tick(); tick();
        chk("rst_mode", int'(mode), 0);
        chk("rst_field", int'(edit_field), 0);
        chk("rst_ld_alarm", int'(LD_alarm), 0);
        chk("rst_ld_time", int'(LD_time), 0);
        chk("rst_stop", int'(stop_alarm), 0);
        release_reset();

        // Time edit 10:20:30 -> 13:22:30
        cur_hour = 6'd10; cur_min = 6'd20; cur_sec = 6'd30;
        press(1, 0, 0, 0);
        repeat (3) press(0, 0, 1, 0);
        press(0, 1, 0, 0);
        repeat (2) press(0, 0, 1, 0);
        press(0, 1, 0, 0);
        press(0, 1, 0, 0);

        // Alarm edit with hour and minute wrap, commit 0:00:00
        press(1, 0, 0, 0);
        press(1, 0, 0, 0);
        repeat (18) press(0, 0, 1, 0);
        press(0, 1, 0, 0);
        repeat (60) press(0, 0, 1, 0);
        press(0, 1, 0, 0);
        press(0, 1, 0, 0);

        // Dismiss restores the programmed alarm
        alarm = 1'b1;
        press(1, 0, 0, 0);

        // Snooze across midnight
        cur_hour = 6'd23; cur_min = 6'd57; cur_sec = 6'd10;
        press(0, 0, 0, 1);
        alarm = 1'b0;

        // Edit timeout
        start = cyc;
        press(1, 0, 0, 0);
        entry = start + 1;
        exit_c = -1;
        for (int k = 0; k < 400; k++) begin
            if (mode == 2'd0) begin
                exit_c = cyc;
                break;
            end
            tick();
        end
        st = 0; f = 0;
        chk("timeout_cycles", exit_c - entry, TO);
        chk("timeout_field", int'(edit_field), 0);

        // Mode and inc together: mode wins, alarm edit starts from unmodified shadow
        press(1, 0, 0, 0);
        press(1, 0, 1, 0);
        press(0, 1, 0, 0);
        press(0, 1, 0, 0);
        press(0, 1, 0, 0);

        // Reset in the SNZ_LD cycle drops the pending load
        alarm = 1'b1;
        cur_hour = 6'd8; cur_min = 6'd30; cur_sec = 6'd5;
        btn_snooze = 1'b1;
        push(2, 0, 0, 0, cyc + 1);
        tick();
        btn_snooze = 1'b0;
        reset = 1'b1;
        tick();
        chk("rst_snz_ld", int'(LD_alarm), 0);
        tick();
        alarm = 1'b0;
        release_reset();

        // Randomized presses
        for (int k = 0; k < 200; k++) begin
            alarm    = ($urandom_range(0, 3) == 0);
            cur_hour = 6'($urandom_range(0, 23));
            cur_min  = 6'($urandom_range(0, 59));
            cur_sec  = 6'($urandom_range(0, 59));
            r = $urandom_range(0, 9);
            if (r < 2)      press(1, 0, 0, 0);
            else if (r < 5) press(0, 1, 0, 0);
            else if (r < 8) press(0, 0, 1, 0);
            else if (r < 9) press(0, 0, 0, 1);
            else            press(1, 0, 1, 0);
        end
        alarm = 1'b0;

        repeat (5) tick();
        chk("pending_pulses", sbq.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/alarm_set_ctrl.md
Name: alarm_set_ctrl

Overview:
User-interface sequencer for the alarm clock core. It turns four debounced push-buttons into correctly sequenced LD_time, LD_alarm and stop_alarm pulses, with matching sec_in/min_in/hour_in values. It provides field-by-field time and alarm editing, snooze and dismiss. It sits between the button debouncers and the clock core, on the same 10 Hz clk.

Parameters:
SNOOZE_MIN, 5, minutes added to the current time on snooze (legal 1..59)
TIMEOUT_TICKS, 300, clk cycles without a button press before an edit aborts (30 s at 10 Hz)
INIT_ALARM_HOUR, 6, alarm hour loaded after reset (minute and second are 0)

Ports:
clk  in  1  system clock, 10 Hz
reset  in  1  synchronous, active-high
btn_mode  in  1  debounced level: enter/cycle edit mode; dismiss while alarm is high
btn_next  in  1  debounced level: advance field; commits on the last field
btn_inc  in  1  debounced level: increment the selected field
btn_snooze  in  1  debounced level: snooze while alarm is high
alarm  in  1  alarm flag from the clock core
cur_sec, cur_min, cur_hour  in  6 each  running time from the clock core
LD_time  out  1  one-cycle load-time pulse to the core
LD_alarm  out  1  one-cycle load-alarm pulse to the core
stop_alarm  out  1  one-cycle stop pulse to the core
sec_in, min_in, hour_in  out  6 each  load values; valid in the cycle LD_* is high
mode  out  2  display mode: 0 = run, 1 = edit time, 2 = edit alarm
edit_field  out  2  0 = hour, 1 = min, 2 = sec (display blink select)

Behaviour:
- Button inputs: each is registered once; an event is a rising edge (btn & ~btn_q). Held buttons give one event only.
- Event priority in the same cycle: mode > next > inc. btn_snooze is honoured only in IDLE with alarm = 1.
- All outputs are registered. A pulse appears in the cycle after the edge that detected the event, and lasts exactly 1 cycle.
- Reset: all outputs 0, mode = 0, edit_field = 0, state = INIT. The alarm shadow register is set to INIT_ALARM_HOUR:00:00, and the edit registers and timeout counter are set to 0.
- State INIT: issue one LD_alarm with the shadow value (the core's alarm registers have no reset), then go to IDLE.
- State IDLE, alarm = 0: btn_mode -> EDIT_TIME. On entry, edit registers <= cur_*, field = hour. All other buttons are ignored.
- State IDLE, alarm = 1: btn_snooze -> SNZ_STOP, capturing cur_* at the press. btn_mode -> DIS_STOP (dismiss; does not enter edit).
- EDIT_TIME / EDIT_ALARM:
  - btn_inc increments the selected field with wrap: hour 23 -> 0, min/sec 59 -> 0. No carry into other fields.
  - btn_next advances field hour -> min -> sec. btn_next on sec moves to COMMIT.
  - btn_mode in EDIT_TIME -> EDIT_ALARM. Time edits are discarded, edit registers <= shadow, field = hour.
  - btn_mode in EDIT_ALARM -> IDLE (abort, no load).
  - Any button event clears the timeout counter. When the counter reaches TIMEOUT_TICKS-1, return to IDLE with no load.
  - alarm and btn_snooze are ignored while editing; stop_alarm stays 0.
- COMMIT: from EDIT_TIME, pulse LD_time with the edit registers. From EDIT_ALARM, pulse LD_alarm and set shadow <= edit registers. Then go to IDLE.
- SNZ_STOP: pulse stop_alarm, then go to SNZ_LD.
- SNZ_LD: pulse LD_alarm with captured time + SNOOZE_MIN:
  - m = min + SNOOZE_MIN, computed in 7 bits. If m >= 60: m -= 60 and hour + 1, with hour 24 -> 0.
  - Seconds are the captured seconds.
  - Shadow is NOT updated. Go to IDLE.
- DIS_STOP: pulse stop_alarm, then go to DIS_LD. DIS_LD pulses LD_alarm with the shadow value (restores the programmed alarm), then goes to IDLE.
- stop_alarm and LD_alarm are never high in the same cycle (the core gives LD_alarm priority). LD_time and LD_alarm are mutually exclusive.
- sec_in/min_in/hour_in are 0 whenever no LD_* pulse is active.
- Reset asserted in any state (including mid-snooze or mid-commit) aborts without a pending pulse and restarts at INIT.

Decomposition:
- Package alarm_ui_pkg: state enum (INIT, IDLE, EDIT_TIME, EDIT_ALARM, COMMIT, SNZ_STOP, SNZ_LD, DIS_STOP, DIS_LD); field enum; constants MAX_HOUR = 23, MAX_MINSEC = 59.
- One sub-module, btn_edge, instanced four times: register plus rising-edge detect.
- Snooze time arithmetic stays inline.

Test Plan:
1. Release reset -> LD_alarm for 1 cycle with hour_in = 6, min_in = 0, sec_in = 0; mode = 0.
2. mode, inc x3, next, inc x2, next, next with cur = 10:20:30 -> LD_time 1 cycle later, with hour_in = 13, min_in = 22, sec_in = 30.
3. Edit alarm: mode, mode, set 23 -> inc wraps the hour to 0, min 59 -> inc gives 0; commit gives LD_alarm 0:00:00. A later dismiss restores 0:00:00.
4. alarm = 1, cur = 23:57:10, snooze -> stop_alarm at cycle +1, then LD_alarm 0:02:10 at cycle +2, never overlapping.
5. Enter EDIT_TIME, no buttons for 300 cycles -> mode returns to 0, and no LD_time ever pulses.
6. Assert reset during the SNZ_LD cycle -> no LD pulse that cycle; INIT LD_alarm 6:00:00 follows release. Also: mode and inc pressed together in EDIT_TIME -> mode wins (mode = 2, no increment).
